// File: rtl/basic_fa_pkg.sv
// basic_fa_pkg -- constants shared by the basic_fa ripple-carry adder slice.
//   BASIC_FA_WIDTH_DEFAULT : default operand width
//   BASIC_FA_WIDTH_MAX     : widest legal operand width
//   S_RESET_VALUE          : reset value of the sum register (sliced to WIDTH)
//   COUT_RESET_VALUE       : reset value of the carry-out register
package basic_fa_pkg;

    localparam int unsigned BASIC_FA_WIDTH_DEFAULT = 1;
    localparam int unsigned BASIC_FA_WIDTH_MAX     = 64;

    localparam logic [BASIC_FA_WIDTH_MAX-1:0] S_RESET_VALUE    = '0;
    localparam logic                          COUT_RESET_VALUE = 1'b0;

endpackage

// File: rtl/basic_fa_cell.sv
// fa_cell -- purely combinational 1-bit full adder.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit   (a ^ b ^ ci)
//   co   : carry out (a&b | ci&(a^b))
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/basic_fa.sv
// basic_fa -- WIDTH-bit ripple-carry adder built from fa_cell, outputs registered.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : qualifies A/B/Cin at this edge
//   A, B      : unsigned addends (WIDTH bits)
//   Cin       : carry into bit 0
//   out_valid : S/Cout carry a new result this cycle
//   S         : registered sum, A+B+Cin mod 2^WIDTH
//   Cout      : registered carry out of bit WIDTH-1
//   Ovf       : registered two's-complement overflow, present only when
//               BASIC_FA_OVERFLOW_EN is defined
module basic_fa
    import basic_fa_pkg::*;
#(
    parameter int unsigned WIDTH = BASIC_FA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef BASIC_FA_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    if (WIDTH == 0 || WIDTH > BASIC_FA_WIDTH_MAX) begin : g_bad_width
        $error("basic_fa: WIDTH out of range 1..64");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Invalid cycles never load the result registers, so X on A/B/Cin
    // during those cycles cannot reach S/Cout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= S_RESET_VALUE[WIDTH-1:0];
            Cout      <= COUT_RESET_VALUE;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum;
                Cout <= carry[WIDTH];
            end
        end
    end

`ifdef BASIC_FA_OVERFLOW_EN
    // carry[WIDTH-1] is Cin when WIDTH==1, giving Cout ^ Cin there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Ovf <= 1'b0;
        end else if (in_valid) begin
            Ovf <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_basic_fa.sv
// tb_basic_fa -- randomized and directed checks of basic_fa at WIDTH=1 and WIDTH=4
// against a plain-arithmetic reference model. Define BASIC_FA_OVERFLOW_EN to
// also check Ovf.
module tb_basic_fa;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0;

    logic       v1, s1, co1;
    logic       v4, co4;
    logic [3:0] s4;
`ifdef BASIC_FA_OVERFLOW_EN
    logic       ovf1, ovf4;
`endif

    // reference model state
    logic       e_v = 1'b0;
    logic       e_s1 = 1'b0, e_c1 = 1'b0, e_o1 = 1'b0;
    logic [3:0] e_s4 = '0;
    logic       e_c4 = 1'b0, e_o4 = 1'b0;

    int unsigned test_cnt = 0;
    int unsigned fail_cnt = 0;

    always #5 clk = ~clk;

    basic_fa #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a1),
        .B         (b1),
        .Cin       (c1),
        .out_valid (v1),
        .S         (s1),
        .Cout      (co1)
`ifdef BASIC_FA_OVERFLOW_EN
        ,
        .Ovf       (ovf1)
`endif
    );

    basic_fa #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a4),
        .B         (b4),
        .Cin       (c4),
        .out_valid (v4),
        .S         (s4),
        .Cout      (co4)
`ifdef BASIC_FA_OVERFLOW_EN
        ,
        .Ovf       (ovf4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " v1"},  64'(v1),  64'(e_v));
        check({tag, " s1"},  64'(s1),  64'(e_s1));
        check({tag, " c1"},  64'(co1), 64'(e_c1));
        check({tag, " v4"},  64'(v4),  64'(e_v));
        check({tag, " s4"},  64'(s4),  64'(e_s4));
        check({tag, " c4"},  64'(co4), 64'(e_c4));
`ifdef BASIC_FA_OVERFLOW_EN
        check({tag, " o1"},  64'(ovf1), 64'(e_o1));
        check({tag, " o4"},  64'(ovf4), 64'(e_o4));
`endif
    endtask

    // Reference: unsigned sum as an integer; overflow as the signed sum
    // leaving the representable two's-complement range.
    task automatic model_edge();
        int sum, sa, sb;
        e_v = in_valid;
        if (in_valid) begin
            sum  = int'(a1) + int'(b1) + int'(c1);
            e_s1 = sum[0];
            e_c1 = sum[1];
            sa   = a1 ? -1 : 0;
            sb   = b1 ? -1 : 0;
            sum  = sa + sb + int'(c1);
            e_o1 = (sum > 0) || (sum < -1);

            sum  = int'(a4) + int'(b4) + int'(c4);
            e_s4 = sum[3:0];
            e_c4 = sum[4];
            sa   = a4[3] ? int'(a4) - 16 : int'(a4);
            sb   = b4[3] ? int'(b4) - 16 : int'(b4);
            sum  = sa + sb + int'(c4);
            e_o4 = (sum > 7) || (sum < -8);
        end
    endtask

    // Drive a sample, clock it in, then check one step after the edge.
    task automatic step(input string tag, input logic v,
                        input logic ia1, input logic ib1, input logic ic1,
                        input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4);
        in_valid = v;
        a1 = ia1; b1 = ib1; c1 = ic1;
        a4 = ia4; b4 = ib4; c4 = ic4;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // reset state
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        rst = 1'b0;

        // all 8 one-bit combinations, one per cycle
        for (int unsigned k = 0; k < 8; k++) begin
            logic [2:0] kb;
            kb = 3'(k);
            step("w1_combo", 1'b1, kb[2], kb[1], kb[0], 4'(k), 4'(k * 3), kb[0]);
        end
        check("w1_last_cs", {62'd0, co1, s1}, 64'd3);

        // directed 4-bit points
        step("w4_wrap",  1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 1'b1);
        check("w4_wrap_s", 64'(s4), 64'h0);
        check("w4_wrap_c", 64'(co4), 64'd1);
        step("w4_78",    1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 4'h8, 1'b0);
        check("w4_78_s", 64'(s4), 64'hF);
        step("w4_allones", 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        check("w4_allones_s", 64'(s4), 64'hF);
        check("w4_allones_c", 64'(co4), 64'd1);
`ifdef BASIC_FA_OVERFLOW_EN
        step("ovf_71",   1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 4'h1, 1'b0);
        check("ovf_71_s", 64'(s4), 64'h8);
        check("ovf_71_o", 64'(ovf4), 64'd1);
        step("ovf_F1",   1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0);
        check("ovf_F1_o", 64'(ovf4), 64'd0);
        check("ovf_F1_c", 64'(co4), 64'd1);
`endif

        // valid toggling 1,0,1 with inputs changing every cycle
        step("tog1", 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h4, 1'b0);
        step("tog0", 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 4'h9, 1'b1);
        check("tog0_hold_s4", 64'(s4), 64'h7);
        step("tog2", 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 4'h6, 1'b1);

        // X on invalid cycle must not leak
        step("xin", 1'b0, 1'bx, 1'bx, 1'bx, 4'bxxxx, 4'bxxxx, 1'bx);

        // reset pulsed between edges with a valid sample pending
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hA; b4 = 4'h7; c4 = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        e_v = 1'b0; e_s1 = 1'b0; e_c1 = 1'b0; e_o1 = 1'b0;
        e_s4 = '0;  e_c4 = 1'b0; e_o4 = 1'b0;
        check_all("rst_async");
        #1;
        rst = 1'b0;
        step("rst_after", 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'h7, 1'b1);
        step("rst_first", 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'h3, 1'b0);

        // randomized back-to-back traffic with random valid
        for (int unsigned n = 0; n < 300; n++) begin
            logic [31:0] r;
            r = $urandom;
            step("rand", (r[0] | r[1]), r[2], r[3], r[4], r[8:5], r[12:9], r[13]);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
